// File: rtl/loop_trip_ctrl_pkg.sv
// Shared definitions for the loop-trip predictor: address width, entry state
// encoding and the default confirmation count.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package loop_trip_ctrl_pkg;

  // Two-bit entry state; the encoding is fixed so that 0 means "free".
  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_TRAIN   = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCK    = 2'd3
  } entry_state_t;

  localparam int CONF_MAX_DEFAULT = 2;
  localparam int ADDR_W           = `ADDR_WIDTH;

endpackage

// File: rtl/loop_trip_entry.sv
// One loop-predictor table entry: holds tag, learned trip count, running
// iteration count and confirmation count, and walks TRAIN -> CHECK -> LOCK.
module loop_trip_entry
  import loop_trip_ctrl_pkg::*;
#(
  parameter int TRIP_W   = 10,
  parameter int CONF_MAX = CONF_MAX_DEFAULT,
  parameter int AW       = ADDR_W
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              alloc,
  input  logic              upd,
  input  logic              taken,
  input  logic              kill,
  input  logic [AW-1:0]     alloc_tag,
  output entry_state_t      state,
  output logic [AW-1:0]     tag,
  output logic [TRIP_W-1:0] trip,
  output logic [TRIP_W-1:0] iter
);

  localparam logic [TRIP_W-1:0] ITER_MAX = '1;
  localparam logic [2:0]        CONF_LIM = 3'(CONF_MAX);

  entry_state_t      state_n;
  logic [AW-1:0]     tag_n;
  logic [TRIP_W-1:0] trip_n;
  logic [TRIP_W-1:0] iter_n;
  logic [1:0]        conf, conf_n;
  logic [2:0]        conf_inc;

  // Next-state and counter update; kill beats allocation beats training.
  always_comb begin
    state_n  = state;
    tag_n    = tag;
    trip_n   = trip;
    iter_n   = iter;
    conf_n   = conf;
    conf_inc = {1'b0, conf} + 3'd1;
    if (kill) begin
      state_n = ST_INVALID;
    end else if (alloc) begin
      state_n = ST_TRAIN;
      tag_n   = alloc_tag;
      iter_n  = {{(TRIP_W-1){1'b0}}, 1'b1};
      conf_n  = '0;
    end else if (upd) begin
      case (state)
        ST_TRAIN: begin
          if (taken) begin
            // Saturation means the loop is longer than we can count: drop it.
            if (iter == ITER_MAX) state_n = ST_INVALID;
            else                  iter_n  = iter + 1'b1;
          end else begin
            trip_n  = iter;
            iter_n  = '0;
            conf_n  = '0;
            state_n = ST_CHECK;
          end
        end
        ST_CHECK, ST_LOCK: begin
          if (taken) begin
            if (iter < trip) iter_n  = iter + 1'b1;
            else             state_n = ST_INVALID;
          end else if (iter == trip) begin
            iter_n = '0;
            if (state == ST_CHECK) begin
              conf_n = conf_inc[1:0];
              if (conf_inc == CONF_LIM) state_n = ST_LOCK;
            end
          end else begin
            state_n = ST_INVALID;
          end
        end
        default: ;
      endcase
    end
  end

  // Entry registers; reset clears everything so lookups see a clean table.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= ST_INVALID;
      tag   <= '0;
      trip  <= '0;
      iter  <= '0;
      conf  <= '0;
    end else begin
      state <= state_n;
      tag   <= tag_n;
      trip  <= trip_n;
      iter  <= iter_n;
      conf  <= conf_n;
    end
  end

endmodule

// File: rtl/loop_trip_ctrl.sv
// Loop-trip controller: fully associative table of loop entries trained from
// EX-stage branch outcomes and looked up combinationally by the fetch PC.
module loop_trip_ctrl
  import loop_trip_ctrl_pkg::*;
#(
  parameter int ENTRIES  = 4,
  parameter int TRIP_W   = 10,
  parameter int CONF_MAX = CONF_MAX_DEFAULT
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [`ADDR_WIDTH-1:0] pc,
  input  logic                   br_valid_ex,
  input  logic [`ADDR_WIDTH-1:0] pc_ex,
  input  logic                   br_taken_ex,
  input  logic                   loop_kill,
  output logic                   loop_hit,
  output logic                   loop_predict_taken,
  output logic                   loop_tracking
);

  localparam int PTR_W = $clog2(ENTRIES);

  entry_state_t            st     [ENTRIES];
  logic [`ADDR_WIDTH-1:0]  tg     [ENTRIES];
  logic [TRIP_W-1:0]       trip_q [ENTRIES];
  logic [TRIP_W-1:0]       iter_q [ENTRIES];

  logic [ENTRIES-1:0] ex_match, upd_vec, alloc_vec;
  logic [PTR_W-1:0]   ptr, victim;
  logic               any_match, found_inv, can_alloc, do_alloc, use_ptr;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    loop_trip_entry #(
      .TRIP_W   (TRIP_W),
      .CONF_MAX (CONF_MAX),
      .AW       (`ADDR_WIDTH)
    ) u_entry (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .alloc     (alloc_vec[g]),
      .upd       (upd_vec[g]),
      .taken     (br_taken_ex),
      .kill      (loop_kill),
      .alloc_tag (pc_ex),
      .state     (st[g]),
      .tag       (tg[g]),
      .trip      (trip_q[g]),
      .iter      (iter_q[g])
    );
  end

  // EX-side tag match and victim choice: lowest free entry, else the
  // round-robin slot unless it holds a locked loop.
  always_comb begin
    found_inv = 1'b0;
    victim    = ptr;
    for (int i = 0; i < ENTRIES; i++) begin
      ex_match[i] = (st[i] != ST_INVALID) && (tg[i] == pc_ex);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (st[i] == ST_INVALID) begin
        found_inv = 1'b1;
        victim    = PTR_W'(i);
      end
    end
    any_match = |ex_match;
    upd_vec   = ex_match & {ENTRIES{br_valid_ex}};
    can_alloc = found_inv || (st[ptr] != ST_LOCK);
    do_alloc  = br_valid_ex && br_taken_ex && !any_match && can_alloc;
    use_ptr   = do_alloc && !found_inv;
    for (int i = 0; i < ENTRIES; i++) begin
      alloc_vec[i] = do_alloc && (victim == PTR_W'(i));
    end
  end

  // Round-robin replacement pointer; kill returns it to slot 0.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst || loop_kill) ptr <= '0;
    else if (use_ptr)         ptr <= ptr + 1'b1;
  end

  // Fetch lookup on registered state; tags are unique so at most one hits.
  always_comb begin
    loop_tracking      = 1'b0;
    loop_hit           = 1'b0;
    loop_predict_taken = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if ((st[i] != ST_INVALID) && (tg[i] == pc)) begin
        loop_tracking = 1'b1;
        if (st[i] == ST_LOCK) begin
          loop_hit           = 1'b1;
          loop_predict_taken = (iter_q[i] != trip_q[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_loop_trip_ctrl.sv
// Bench for loop_trip_ctrl: directed branch streams, a per-cycle reference
// model of the loop table, and literal expectations from hand traces.
module tb_loop_trip_ctrl;

  localparam int AW   = 32;
  localparam int N    = 4;
  localparam int IMAX = 1023;
  localparam int S_IN = 0, S_TR = 1, S_CK = 2, S_LK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, bv, tk, kill;
  logic [AW-1:0] pc, pc_ex;
  logic          hit, pred, track;

  logic          rst4, bv4, tk4, kill4;
  logic [AW-1:0] pc4, pc_ex4;
  logic          hit4, pred4, track4;

  loop_trip_ctrl #(.ENTRIES(4), .TRIP_W(10), .CONF_MAX(2)) dut (
    .cpu_clk(clk), .cpu_rst(rst), .pc(pc), .br_valid_ex(bv), .pc_ex(pc_ex),
    .br_taken_ex(tk), .loop_kill(kill), .loop_hit(hit),
    .loop_predict_taken(pred), .loop_tracking(track));

  loop_trip_ctrl #(.ENTRIES(4), .TRIP_W(4), .CONF_MAX(2)) dut4 (
    .cpu_clk(clk), .cpu_rst(rst4), .pc(pc4), .br_valid_ex(bv4), .pc_ex(pc_ex4),
    .br_taken_ex(tk4), .loop_kill(kill4), .loop_hit(hit4),
    .loop_predict_taken(pred4), .loop_tracking(track4));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model of the table (one record per entry).
  int            m_st   [N];
  logic [AW-1:0] m_tag  [N];
  int            m_trip [N];
  int            m_iter [N];
  int            m_conf [N];
  int            m_ptr;

  task automatic model_train(input int e, input logic t);
    if (m_st[e] == S_TR) begin
      if (t) begin
        if (m_iter[e] == IMAX) m_st[e] = S_IN;
        else m_iter[e]++;
      end else begin
        m_trip[e] = m_iter[e]; m_iter[e] = 0; m_conf[e] = 0; m_st[e] = S_CK;
      end
    end else begin
      if (t) begin
        if (m_iter[e] < m_trip[e]) m_iter[e]++;
        else m_st[e] = S_IN;
      end else if (m_iter[e] == m_trip[e]) begin
        m_iter[e] = 0;
        if (m_st[e] == S_CK) begin
          m_conf[e]++;
          if (m_conf[e] == 2) m_st[e] = S_LK;
        end
      end else begin
        m_st[e] = S_IN;
      end
    end
  endtask

  always @(posedge clk) begin
    int h, v;
    if (rst || kill) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = S_IN;
        if (rst) begin m_tag[i] = '0; m_trip[i] = 0; m_iter[i] = 0; m_conf[i] = 0; end
      end
      m_ptr = 0;
    end else if (bv) begin
      h = -1;
      for (int i = 0; i < N; i++) if (m_st[i] != S_IN && m_tag[i] == pc_ex) h = i;
      if (h >= 0) model_train(h, tk);
      else if (tk) begin
        v = -1;
        for (int i = N - 1; i >= 0; i--) if (m_st[i] == S_IN) v = i;
        if (v < 0 && m_st[m_ptr] != S_LK) begin v = m_ptr; m_ptr = (m_ptr + 1) % N; end
        if (v >= 0) begin
          m_st[v] = S_TR; m_tag[v] = pc_ex; m_iter[v] = 1; m_conf[v] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of the lookup outputs against the model.
  always @(negedge clk) begin
    logic et, eh, ep;
    if (chk_en) begin
      et = 1'b0; eh = 1'b0; ep = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] != S_IN && m_tag[i] == pc) begin
          et = 1'b1;
          if (m_st[i] == S_LK) begin eh = 1'b1; ep = (m_iter[i] != m_trip[i]); end
        end
      end
      check("cyc_tracking", track, et);
      check("cyc_hit", hit, eh);
      check("cyc_pred", pred, ep);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [AW-1:0] a, input logic t);
    bv = 1'b1; pc_ex = a; tk = t;
    tick();
    bv = 1'b0;
  endtask

  task automatic run(input logic [AW-1:0] a, input int n, input bit exit_nt);
    for (int k = 0; k < n; k++) ex(a, 1'b1);
    if (exit_nt) ex(a, 1'b0);
  endtask

  task automatic lk(input string nm, input logic [AW-1:0] a,
                    input logic eh, input logic ep, input logic et);
    pc = a;
    #2;
    check({nm, "_hit"}, hit, eh);
    check({nm, "_pred"}, pred, ep);
    check({nm, "_tracking"}, track, et);
  endtask

  task automatic ex4(input logic t);
    bv4 = 1'b1; pc_ex4 = 32'h100; tk4 = t;
    tick();
    bv4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0; bv = 1'b0; tk = 1'b0; pc = '0; pc_ex = '0;
    rst4 = 1'b1; kill4 = 1'b0; bv4 = 1'b0; tk4 = 1'b0; pc4 = 32'h100; pc_ex4 = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0; rst4 = 1'b0;
    lk("reset", 32'h100, 1'b0, 1'b0, 1'b0);

    // Not-taken only: nothing is allocated.
    ex(32'h100, 1'b0); ex(32'h104, 1'b0); ex(32'h100, 1'b0);
    lk("nt_only", 32'h100, 1'b0, 1'b0, 1'b0);

    // Three T,T,T,N runs lock the entry with trip=3.
    run(32'h100, 3, 1'b1);
    lk("after_run1", 32'h100, 1'b0, 1'b0, 1'b1);
    run(32'h100, 3, 1'b1);
    run(32'h100, 3, 1'b1);
    lk("locked", 32'h100, 1'b1, 1'b1, 1'b1);

    // Fourth run: lookup in the same cycle as each update sees pre-update state.
    pc = 32'h100;
    for (int k = 0; k < 4; k++) begin
      bv = 1'b1; pc_ex = 32'h100; tk = (k < 3);
      #2;
      check("run4_pred", pred, k < 3);
      check("run4_hit", hit, 1'b1);
      tick();
    end
    bv = 1'b0;

    // Too-short run drops the entry.
    run(32'h100, 2, 1'b1);
    lk("short_run", 32'h100, 1'b0, 1'b0, 1'b0);

    // Relock, then a too-long run drops it on the 4th taken.
    repeat (3) run(32'h100, 3, 1'b1);
    lk("relock", 32'h100, 1'b1, 1'b1, 1'b1);
    run(32'h100, 3, 1'b0);
    lk("long_run_3", 32'h100, 1'b1, 1'b0, 1'b1);
    run(32'h100, 1, 1'b0);
    lk("long_run_4", 32'h100, 1'b0, 1'b0, 1'b0);

    // Replacement with all entries in TRAIN.
    kill = 1'b1; tick(); kill = 1'b0;
    ex(32'h100, 1'b1); ex(32'h104, 1'b1); ex(32'h108, 1'b1); ex(32'h10C, 1'b1);
    ex(32'h200, 1'b1);
    lk("repl_old", 32'h100, 1'b0, 1'b0, 1'b0);
    lk("repl_new", 32'h200, 1'b0, 1'b0, 1'b1);
    lk("repl_keep", 32'h104, 1'b0, 1'b0, 1'b1);
    ex(32'h300, 1'b1);
    lk("ptr_adv", 32'h104, 1'b0, 1'b0, 1'b0);
    lk("ptr_keep", 32'h108, 1'b0, 1'b0, 1'b1);

    // All four locked: a new taken branch allocates nothing.
    kill = 1'b1; tick(); kill = 1'b0;
    for (int a = 0; a < 4; a++) repeat (3) run(32'h100 + 4 * a, 3, 1'b1);
    ex(32'h300, 1'b1);
    lk("full_lock_miss", 32'h300, 1'b0, 1'b0, 1'b0);
    lk("full_lock_keep", 32'h10C, 1'b1, 1'b1, 1'b1);

    // Kill beats a same-cycle update that would have locked the entry.
    kill = 1'b1; tick(); kill = 1'b0;
    repeat (2) run(32'h100, 3, 1'b1);
    run(32'h100, 3, 1'b0);
    kill = 1'b1; bv = 1'b1; pc_ex = 32'h100; tk = 1'b0;
    tick();
    kill = 1'b0; bv = 1'b0;
    lk("kill_prio", 32'h100, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of training clears the table next cycle.
    run(32'h104, 2, 1'b0);
    lk("pre_rst", 32'h104, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; tick();
    lk("mid_rst", 32'h104, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; tick();

    // Saturation on the 4-bit instance: 15 takens fit, the 16th drops it.
    pc4 = 32'h100;
    #2;
    check("sat_reset_tracking", track4, 1'b0);
    repeat (15) ex4(1'b1);
    #2;
    check("sat_15_tracking", track4, 1'b1);
    check("sat_15_hit", hit4, 1'b0);
    ex4(1'b1);
    #2;
    check("sat_16_tracking", track4, 1'b0);
    check("sat_16_pred", pred4, 1'b0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
